arr_divider_seq: RTL and testbench

ARR_DIVIDER_SEQ -- requirements
Module: arr_divider_seq

---
 rtl/arr_div_pkg.sv | 12 +
 rtl/div_step.sv | 27 ++
 rtl/arr_divider_seq.sv | 127 ++++++++++++
 tb/tb_arr_divider_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arr_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package arr_div_pkg;

  localparam int unsigned DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare, subtract.
module div_step
  import arr_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem_c,
  output logic             o_qbit_c
);

  // The shifted partial remainder needs WIDTH+1 bits so the compare cannot overflow.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Shift, compare against the divisor and restore when the subtraction would go negative.
  always_comb begin
    w_shift  = {i_rem, i_bit};
    w_diff   = w_shift - {1'b0, i_dvs};
    o_qbit_c = (w_shift >= {1'b0, i_dvs});
    // The result is always below the divisor, so it fits back into WIDTH bits.
    o_rem_c  = o_qbit_c ? WIDTH'(w_diff) : WIDTH'(w_shift);
  end

endmodule

// File: rtl/arr_divider_seq.sv
// Sequential unsigned divider: one restoring step per clock, results presented with a done pulse.
module arr_divider_seq
  import arr_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  div_state_e       r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_dvd,    w_dvd_nxt;
  logic [WIDTH-1:0] r_dvs,    w_dvs_nxt;
  logic [WIDTH-1:0] r_rem,    w_rem_nxt;
  logic [WIDTH-1:0] r_quo,    w_quo_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_dbz_nxt;
  logic [WIDTH-1:0] w_quo_o_nxt;
  logic [WIDTH-1:0] w_rem_o_nxt;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_dvd[WIDTH-1]),
    .i_dvs    (r_dvs),
    .o_rem_c  (w_step_rem),
    .o_qbit_c (w_step_q)
  );

  // Next-state and next-output decode; a new start in IDLE or DONE overrides the case result.
  always_comb begin
    w_state_nxt = r_state;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_cnt_nxt   = r_cnt;
    w_zero_nxt  = r_zero;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = div_by_zero;
    w_quo_o_nxt = Quotient;
    w_rem_o_nxt = Remainder;

    case (r_state)
      RUN: begin
        w_rem_nxt = w_step_rem;
        w_quo_nxt = {r_quo[WIDTH-2:0], w_step_q};
        w_dvd_nxt = {r_dvd[WIDTH-2:0], 1'b0};
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      DONE: begin
        // Divide-by-zero never shifts, so r_dvd still holds the original dividend.
        w_done_nxt  = 1'b1;
        w_dbz_nxt   = r_zero;
        w_quo_o_nxt = r_zero ? '1 : r_quo;
        w_rem_o_nxt = r_zero ? r_dvd : r_rem;
        w_state_nxt = IDLE;
      end
      default: ;
    endcase

    if (start && (r_state != RUN)) begin
      w_dvd_nxt   = A;
      w_dvs_nxt   = B;
      w_rem_nxt   = '0;
      w_quo_nxt   = '0;
      w_cnt_nxt   = '0;
      w_zero_nxt  = (B == '0);
      w_state_nxt = (B == '0) ? DONE : RUN;
      w_busy_nxt  = (B != '0);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dvd       <= w_dvd_nxt;
      r_dvs       <= w_dvs_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_cnt       <= w_cnt_nxt;
      r_zero      <= w_zero_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      div_by_zero <= w_dbz_nxt;
      Quotient    <= w_quo_o_nxt;
      Remainder   <= w_rem_o_nxt;
    end
  end

endmodule

// File: tb/tb_arr_divider_seq.sv
// Scoreboard bench for arr_divider_seq at WIDTH=4.
module tb_arr_divider_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  arr_divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Quotient    (Quotient),
    .Remainder   (Remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 4'hF; e.r = 4'(a); e.dbz = 1'b1;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int a, input int b, input bit push);
    A = 4'(a);
    B = 4'(b);
    start = 1'b1;
    if (push) sb.push_back(model(a, b));
    tick();
    start = 1'b0;
  endtask

  // Counts edges from the current sample point until done is seen.
  task automatic wait_done(output int edges, output int busy_cnt);
    busy_cnt = int'(busy);
    edges = 0;
    do begin
      tick();
      edges++;
      if (!done) busy_cnt += int'(busy);
    end while (!done && edges < 40);
    if (!done) check("timeout_done", 32'(done), 1);
  endtask

  // Result monitor: every done pulse pops one expectation.
  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(Quotient), 32'(e.q));
        check("remainder", 32'(Remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  initial begin
    int edges, bcnt, nd;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    check("rst_q", 32'(Quotient), 0);
    check("rst_r", 32'(Remainder), 0);
    rst = 1'b0;
    tick();

    // 13/3 latency, busy length and result hold
    start_op(13, 3, 1);
    wait_done(edges, bcnt);
    check("t13_3_latency", edges, 5);
    check("t13_3_busy_cycles", bcnt, 4);
    tick(); tick();
    check("t13_3_done_pulse", 32'(done), 0);
    check("t13_3_hold_q", 32'(Quotient), 4);
    check("t13_3_hold_r", 32'(Remainder), 1);

    // divide by zero
    start_op(7, 0, 1);
    check("t7_0_busy", 32'(busy), 0);
    wait_done(edges, bcnt);
    check("t7_0_latency", edges, 1);
    check("t7_0_busy_cycles", bcnt, 0);
    tick();

    // back-to-back: second start lands in the DONE cycle
    start_op(2, 9, 1);
    repeat (4) tick();
    check("b2b_done_early", 32'(done), 0);
    A = 4'd15; B = 4'd1; start = 1'b1;
    sb.push_back(model(15, 1));
    tick();
    start = 1'b0;
    check("b2b_done", 32'(done), 1);
    check("b2b_busy", 32'(busy), 1);
    wait_done(edges, bcnt);
    check("b2b_latency2", edges, 5);
    tick();

    // start during RUN is ignored
    start_op(12, 5, 1);
    tick();
    A = 4'd1; B = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(edges, bcnt);
    check("ignore_latency", edges, 3);
    tick();

    // reset during the second RUN cycle aborts without done
    start_op(9, 2, 0);
    tick();
    nd = n_done;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_dbz", 32'(div_by_zero), 0);
    check("abort_q", 32'(Quotient), 0);
    check("abort_r", 32'(Remainder), 0);
    repeat (8) tick();
    check("abort_no_done", n_done, nd);
    start_op(9, 2, 1);
    wait_done(edges, bcnt);
    check("fresh_9_2_latency", edges, 5);
    tick();

    // exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(a, b, 1);
        wait_done(edges, bcnt);
        check("sweep_latency", edges, (b == 0) ? 1 : 5);
      end
    end
    tick(); tick();
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
